edge_drive: RTL and testbench



---
 rtl/edge_drive_pkg.sv | 15 +
 rtl/edge_drive_tick_down_cnt.sv | 37 +++
 rtl/edge_drive.sv | 143 ++++++++++++++
 tb/tb_edge_drive.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/edge_drive_pkg.sv
// Shared definitions for the edge_drive output driver:
// state encoding and tick-parameter legality helper.
package edge_drive_pkg;

    typedef enum logic [1:0] {
        ST_STABLE = 2'd0,
        ST_HOLD   = 2'd1,
        ST_PULSE  = 2'd2
    } state_e;

    function automatic bit ticks_ok(input int ticks, input int cnt_w);
        return (ticks >= 1) && (ticks <= (1 << cnt_w) - 1);
    endfunction

endpackage

// File: rtl/edge_drive_tick_down_cnt.sv
// Loadable down-counter that advances only on timebase ticks;
// last flags the tick that consumes the final count.
module tick_down_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        // A load on the same edge as a tick wins; that tick is not counted.
        if (load) begin
            cnt_d = load_val;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign last = tick && (cnt_q == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/edge_drive.sv
// Drives one board-level control line from level/pulse requests with
// tick-timed hold and pulse widths, plus sticky clearable event flags.
module edge_drive
    import edge_drive_pkg::*;
#(
    parameter int HOLD_TICKS  = 2,
    parameter int PULSE_TICKS = 4,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic t30p5us,
    input  logic level_req,
    input  logic pulse_req,
    input  logic edge_clear,
    output logic signal_out,
    output logic busy,
    output logic rising_edge,
    output logic falling_edge,
    output logic pulse_done,
    output logic req_drop
);

    if (!ticks_ok(HOLD_TICKS, CNT_W)) begin : g_bad_hold
        $error("edge_drive: HOLD_TICKS out of range for CNT_W");
    end
    if (!ticks_ok(PULSE_TICKS, CNT_W)) begin : g_bad_pulse
        $error("edge_drive: PULSE_TICKS out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] HOLD_V  = CNT_W'(HOLD_TICKS);
    localparam logic [CNT_W-1:0] PULSE_V = CNT_W'(PULSE_TICKS);

    state_e state_q, state_d;
    logic sig_q, sig_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;
    logic done_q, done_d;
    logic drop_q, drop_d;

    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             last;
    logic             rise_set, fall_set, done_set, drop_set;

    tick_down_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .tick     (t30p5us),
        .load     (load),
        .load_val (load_val),
        .last     (last)
    );

    always_comb begin
        state_d  = state_q;
        sig_d    = sig_q;
        load     = 1'b0;
        load_val = '0;
        rise_set = 1'b0;
        fall_set = 1'b0;
        done_set = 1'b0;
        drop_set = 1'b0;
        unique case (state_q)
            ST_STABLE: begin
                if (level_req != sig_q) begin
                    sig_d    = level_req;
                    load     = 1'b1;
                    load_val = HOLD_V;
                    state_d  = ST_HOLD;
                    rise_set = level_req;
                    fall_set = !level_req;
                    drop_set = pulse_req;
                end else if (pulse_req) begin
                    if (!sig_q) begin
                        sig_d    = 1'b1;
                        load     = 1'b1;
                        load_val = PULSE_V;
                        state_d  = ST_PULSE;
                        rise_set = 1'b1;
                    end else begin
                        drop_set = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                drop_set = pulse_req;
                if (last) begin
                    state_d = ST_STABLE;
                end
            end
            ST_PULSE: begin
                drop_set = pulse_req;
                if (last) begin
                    sig_d    = 1'b0;
                    fall_set = 1'b1;
                    done_set = 1'b1;
                    load     = 1'b1;
                    load_val = HOLD_V;
                    state_d  = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_STABLE;
                sig_d   = 1'b0;
            end
        endcase
    end

    // Clear beats a coincident set.
    always_comb begin
        rise_d = (rise_q | rise_set) & !edge_clear;
        fall_d = (fall_q | fall_set) & !edge_clear;
        done_d = (done_q | done_set) & !edge_clear;
        drop_d = (drop_q | drop_set) & !edge_clear;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_STABLE;
            sig_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    assign signal_out   = sig_q;
    assign busy         = (state_q == ST_HOLD) || (state_q == ST_PULSE);
    assign rising_edge  = rise_q;
    assign falling_edge = fall_q;
    assign pulse_done   = done_q;
    assign req_drop     = drop_q;

endmodule

// File: tb/tb_edge_drive.sv
// Randomised and directed bench for edge_drive, checked per cycle
// against a tick-timer reference model through an expectation queue.
module tb_edge_drive;

    localparam int HOLD  = 2;
    localparam int PULSE = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic t30p5us = 1'b0;
    logic level_req = 1'b0;
    logic pulse_req = 1'b0;
    logic edge_clear = 1'b0;
    logic signal_out, busy, rising_edge, falling_edge, pulse_done, req_drop;

    edge_drive #(.HOLD_TICKS(HOLD), .PULSE_TICKS(PULSE), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .t30p5us      (t30p5us),
        .level_req    (level_req),
        .pulse_req    (pulse_req),
        .edge_clear   (edge_clear),
        .signal_out   (signal_out),
        .busy         (busy),
        .rising_edge  (rising_edge),
        .falling_edge (falling_edge),
        .pulse_done   (pulse_done),
        .req_drop     (req_drop)
    );

    always #5 clk = ~clk;

    // Reference model: line level plus "ticks left" before the line may
    // change again; a pulse needs its high time to run out before the hold.
    int  m_left = 0;
    bit  m_pulsing = 0;
    bit  m_sig = 0;
    bit  m_rise = 0, m_fall = 0, m_done = 0, m_drop = 0;
    int  rises = 0, falls = 0;

    logic [5:0] exp_q[$];
    int checks = 0;
    int passed = 0;
    int cyc_n  = 0;
    bit stim_done = 0;

    task automatic model_step(input bit rst, input bit lvl, input bit pls,
                              input bit tk, input bit clr);
        bit r, f, d, dr;
        r = 0; f = 0; d = 0; dr = 0;
        if (rst) begin
            m_left = 0; m_pulsing = 0; m_sig = 0;
            m_rise = 0; m_fall = 0; m_done = 0; m_drop = 0;
            return;
        end
        if (m_left == 0) begin
            if (lvl != m_sig) begin
                m_sig = lvl; m_left = HOLD; m_pulsing = 0;
                r = lvl; f = !lvl; dr = pls;
            end else if (pls) begin
                if (!m_sig) begin
                    m_sig = 1; m_left = PULSE; m_pulsing = 1; r = 1;
                end else begin
                    dr = 1;
                end
            end
        end else begin
            dr = pls;
            if (tk) begin
                m_left--;
                if (m_left == 0 && m_pulsing) begin
                    m_sig = 0; f = 1; d = 1;
                    m_left = HOLD; m_pulsing = 0;
                end
            end
        end
        rises += int'(r);
        falls += int'(f);
        m_rise = (m_rise | r) & !clr;
        m_fall = (m_fall | f) & !clr;
        m_done = (m_done | d) & !clr;
        m_drop = (m_drop | dr) & !clr;
    endtask

    task automatic cyc(input bit rst, input bit lvl, input bit pls,
                       input bit tk, input bit clr);
        @(negedge clk);
        reset = rst; level_req = lvl; pulse_req = pls;
        t30p5us = tk; edge_clear = clr;
        model_step(rst, lvl, pls, tk, clr);
        exp_q.push_back({m_sig, m_left > 0, m_rise, m_fall, m_done, m_drop});
    endtask

    // Monitor: each expectation describes the outputs after the next edge.
    initial begin
        logic [5:0] exp, act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                act = {signal_out, busy, rising_edge, falling_edge,
                       pulse_done, req_drop};
                cyc_n++;
                checks++;
                if (act === exp) passed++;
                else $display("FAIL cyc%0d sig/busy/rise/fall/done/drop got=%b exp=%b",
                              cyc_n, act, exp);
            end
        end
    end

    initial begin
        int rises0, falls0;
        // 1: reset with level_req high, then release
        repeat (3) cyc(1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 0);
        // 2: drop level 1 clk after a raise; hold must expire first
        repeat (3) cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, (i % 3) == 2, 0);
        // 3+4: pulse with a second request mid-pulse
        repeat (2) cyc(0, 0, 0, 0, 1);
        rises0 = rises; falls0 = falls;
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 24; i++) cyc(0, 0, i == 4, (i % 3) == 1, 0);
        checks++;
        if (rises - rises0 == 1 && falls - falls0 == 1) passed++;
        else $display("FAIL pulse_edges got rise=%0d fall=%0d need 1/1",
                      rises - rises0, falls - falls0);
        // 5: clear coincident with the pulse end, then a later rise
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 24; i++) begin
            bit tk;
            tk = (i % 3) == 0;
            cyc(0, 0, 0, tk, tk && m_pulsing && m_left == 1);
        end
        cyc(0, 1, 0, 0, 0);
        // 6: reset on the second tick of a pulse
        repeat (2) cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            bit tk;
            tk = (i % 2) == 1;
            cyc(m_pulsing && m_left == PULSE - 1 && tk, 0, 0, tk, 0);
        end
        // random
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 299) == 0,
                ($urandom_range(0, 9) == 0) ? !level_req : level_req,
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 19) == 0);
        end
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain got=%0d pending need 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
